// File: rtl/mem_access_seq_if.sv
// Request, memory and size-handler signals of mem_access_seq.
// master = the sequencer, slave = control unit / memory / size handler side.
interface mem_access_seq_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  sh_sel;
    logic [31:0] sh_mem;
    logic [31:0] sh_b;
    logic [31:0] sh_out;
    logic [31:0] load_data;

    modport master (
        input  start, op, addr, store_data, mem_rdata, sh_out,
        output busy, done, misalign, mem_addr, mem_wr, mem_wdata,
               sh_sel, sh_mem, sh_b, load_data
    );

    modport slave (
        output start, op, addr, store_data, mem_rdata, sh_out,
        input  busy, done, misalign, mem_addr, mem_wr, mem_wdata,
               sh_sel, sh_mem, sh_b, load_data
    );
endinterface

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer feeding the byte-lane size handler.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned lh/sh/lw/sw (misalign pulse, no access).
module mem_access_seq #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, CAPTURE, MERGE, WRITE, DONE} state_t;

    localparam logic [2:0] OP_SB   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_SH   = 3'b010;
    localparam logic [2:0] OP_LB   = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_LH   = 3'b101;
    localparam logic [2:0] SEL_OFF = 3'b111;
    localparam logic [3:0] LAT_LAST = 4'(MEM_RD_LAT - 1);

    state_t      r_state;
    logic [2:0]  r_op;
    logic [3:0]  r_cnt;
    logic        r_mis_pend;
    logic        r_busy, r_done, r_misalign, r_mem_wr;
    logic [31:0] r_mem_addr, r_mem_wdata, r_sh_mem, r_sh_b, r_load_data;
    logic [2:0]  r_sh_sel;
    logic        w_illegal, w_misalign, w_is_load;

    always_comb begin
        w_illegal = (bus.op > OP_LH);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        w_misalign = ((bus.op == OP_LH || bus.op == OP_SH) && bus.addr[0]) ||
                     ((bus.op == OP_LW || bus.op == OP_SW) && (bus.addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_is_load = (r_op == OP_LB) || (r_op == OP_LW) || (r_op == OP_LH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= 3'b000;
            r_cnt       <= 4'd0;
            r_mis_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_sh_mem    <= 32'd0;
            r_sh_b      <= 32'd0;
            r_load_data <= 32'd0;
            r_sh_sel    <= SEL_OFF;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_sh_sel   <= SEL_OFF;
            unique case (r_state)
                IDLE: if (bus.start) begin
                    r_op       <= bus.op;
                    r_mem_addr <= bus.addr;
                    r_sh_b     <= bus.store_data;
                    r_cnt      <= 4'd0;
                    r_busy     <= 1'b1;
                    if (w_illegal) begin
                        r_state <= DONE;
                    end else if (w_misalign) begin
                        r_state    <= DONE;
                        r_mis_pend <= 1'b1;
                    end else if (bus.op == OP_SW) begin
                        // sw replaces the whole word, so the read is skipped
                        r_state  <= MERGE;
                        r_sh_sel <= OP_SW;
                    end else begin
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAT_LAST) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_sh_mem <= bus.mem_rdata;
                    r_sh_sel <= r_op;
                    r_state  <= MERGE;
                end
                MERGE: begin
                    if (w_is_load) begin
                        r_load_data <= bus.sh_out;
                        r_state     <= DONE;
                    end else begin
                        r_mem_wdata <= bus.sh_out;
                        r_mem_wr    <= 1'b1;
                        r_state     <= WRITE;
                    end
                end
                WRITE: r_state <= DONE;
                DONE: begin
                    // done trails the DONE state by one cycle so it lands on the IDLE cycle
                    r_done     <= 1'b1;
                    r_misalign <= r_mis_pend;
                    r_mis_pend <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.misalign  = r_misalign;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.sh_sel    = r_sh_sel;
    assign bus.sh_mem    = r_sh_mem;
    assign bus.sh_b      = r_sh_b;
    assign bus.load_data = r_load_data;
endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (read latency 1 and 3) checked every cycle
// against a request-level model, plus literal expectations from hand-worked examples.
module tb_mem_access_seq;
    localparam int NI = 2;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [2:0] SB = 3'd0, SW = 3'd1, SH = 3'd2, LB = 3'd3, LW = 3'd4, LH = 3'd5, BAD = 3'd6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        start [NI];
    logic [2:0]  op [NI];
    logic [31:0] addr [NI], bdat [NI];
    logic        busy [NI], done [NI], mis [NI], mem_wr [NI];
    logic [2:0]  sh_sel [NI];
    logic [31:0] mem_addr [NI], mem_wdata [NI], load_data [NI], sh_mem [NI], sh_b [NI];
    logic [31:0] mem [NI][16];

    // request-level model: accept cycle, latency, expected write and load results
    int          acc_a [NI], acc_lat [NI], wr_at [NI];
    bit          acc_mem [NI], exp_mis [NI];
    logic [31:0] exp_wd [NI], exp_ma [NI], ld_model [NI], ld_prev [NI];
    int          wr_cnt [NI], last_done [NI];
    bit          last_mis [NI];

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // size handler: memory is little-endian, registers big-endian
    function automatic logic [31:0] handler(input logic [2:0] sel, input logic [31:0] m, input logic [31:0] b);
        logic [31:0] s;
        s = bswap(m);
        case (sel)
            3'd0:    return {b[7:0], s[23:0]};
            3'd1:    return bswap(b);
            3'd2:    return {b[7:0], b[15:8], s[15:0]};
            3'd3:    return {s[31:24], 24'h0};
            3'd4:    return s;
            3'd5:    return {s[31:16], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] ah [16];
        mem_access_seq_if bus ();
        assign bus.start      = start[g];
        assign bus.op         = op[g];
        assign bus.addr       = addr[g];
        assign bus.store_data = bdat[g];
        assign bus.mem_rdata  = mem[g][ah[L-1][5:2]];
        assign bus.sh_out     = handler(bus.sh_sel, bus.sh_mem, bus.sh_b);
        assign busy[g]        = bus.busy;
        assign done[g]        = bus.done;
        assign mis[g]         = bus.misalign;
        assign mem_wr[g]      = bus.mem_wr;
        assign mem_addr[g]    = bus.mem_addr;
        assign mem_wdata[g]   = bus.mem_wdata;
        assign load_data[g]   = bus.load_data;
        assign sh_sel[g]      = bus.sh_sel;
        assign sh_mem[g]      = bus.sh_mem;
        assign sh_b[g]        = bus.sh_b;
        always @(posedge clk) begin
            ah[0] <= bus.mem_addr;
            for (int i = 1; i < 16; i++) ah[i] <= ah[i-1];
        end
        mem_access_seq #(.MEM_RD_LAT(L)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    end

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s cyc=%0d got=%h want=%h", g, nm, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        for (int g = 0; g < NI; g++) begin
            bit bx, dx, wx;
            logic [31:0] lx;
            bx = (cyc >= acc_a[g]) && (cyc < acc_a[g] + acc_lat[g]);
            dx = (cyc == acc_a[g] + acc_lat[g]);
            wx = (cyc == wr_at[g]);
            chk(g, "busy", busy[g], bx);
            chk(g, "done", done[g], dx);
            chk(g, "mem_wr", mem_wr[g], wx);
            chk(g, "misalign", mis[g], dx && exp_mis[g]);
            if (mem_wr[g]) begin
                chk(g, "wdata", mem_wdata[g], exp_wd[g]);
                chk(g, "waddr", mem_addr[g], exp_ma[g]);
                mem[g][mem_addr[g][5:2]] = mem_wdata[g];
                wr_cnt[g]++;
            end
            if (done[g]) begin
                last_done[g] = cyc;
                last_mis[g]  = mis[g];
            end
            if (!bx) begin
                lx = (cyc >= acc_a[g] + acc_lat[g]) ? ld_model[g] : ld_prev[g];
                chk(g, "load_data", load_data[g], lx);
                chk(g, "sh_sel_idle", {29'd0, sh_sel[g]}, 32'd7);
            end else if (acc_mem[g]) begin
                chk(g, "mem_addr", mem_addr[g], exp_ma[g]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            acc_a[g] = -100; acc_lat[g] = 0; wr_at[g] = -100;
            acc_mem[g] = 1'b0; exp_mis[g] = 1'b0;
            ld_model[g] = 32'h0; ld_prev[g] = 32'h0;
            start[g] = 1'b0; op[g] = 3'd0; addr[g] = 32'h0; bdat[g] = 32'h0;
            for (int i = 0; i < 16; i++) mem[g][i] = 32'(32'h01010101 * i);
            mem[g][0] = 32'h11223344; mem[g][1] = 32'h11223344;
            mem[g][2] = 32'h55667788; mem[g][3] = 32'hA0B0C0D0;
        end
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Present one request; with full=1 run to the done cycle, otherwise return in the accept cycle.
    task automatic issue(input int g, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input bit full, output int a_out);
        bit ill, mv, ld, st;
        int lat;
        logic [31:0] w;
        ill = (o > LH);
        ld  = (o == LB) || (o == LW) || (o == LH);
        st  = (o == SB) || (o == SW) || (o == SH);
        mv  = ALIGN && (((o == LH || o == SH) && a[0]) || ((o == LW || o == SW) && (a[1:0] != 2'b00)));
        w   = mem[g][a[5:2]];
        if (ill || mv)   lat = 1;
        else if (o == SW) lat = 3;
        else if (ld)     lat = ((g == 0) ? 1 : 3) + 3;
        else             lat = ((g == 0) ? 1 : 3) + 4;
        ld_prev[g] = ld_model[g];
        if (ld && !mv) ld_model[g] = handler(o, w, 32'h0);
        exp_wd[g]  = handler(o, w, b);
        exp_ma[g]  = a;
        exp_mis[g] = mv;
        acc_mem[g] = !ill && !mv;
        acc_a[g]   = cyc + 1;
        acc_lat[g] = lat;
        wr_at[g]   = (st && !mv) ? acc_a[g] + lat - 2 : -100;
        a_out      = acc_a[g];
        start[g] = 1'b1; op[g] = o; addr[g] = a; bdat[g] = b;
        tick();
        start[g] = poke; op[g] = LW; addr[g] = 32'h0000_0030; bdat[g] = 32'hFFFF_FFFF;
        if (!full) begin
            start[g] = 1'b0;
            return;
        end
        tick();
        start[g] = 1'b0;
        repeat (lat - 1) tick();
    endtask

    initial begin
        int a, wc, ld0;
        do_reset(3);
        for (int g = 0; g < NI; g++) begin
            chk(g, "rst_sh_sel", {29'd0, sh_sel[g]}, 32'd7);
            chk(g, "rst_mem_addr", mem_addr[g], 32'h0);
            chk(g, "rst_mem_wdata", mem_wdata[g], 32'h0);
            chk(g, "rst_sh_mem", sh_mem[g], 32'h0);
            chk(g, "rst_sh_b", sh_b[g], 32'h0);
            chk(g, "rst_load_data", load_data[g], 32'h0);
            wr_cnt[g] = 0; last_done[g] = 0; last_mis[g] = 1'b0;
        end
        tick();

        wc = wr_cnt[0];
        issue(0, LW, 32'h0, 32'h0, 1'b0, 1'b1, a);
        chk(0, "T1_lat", last_done[0] - a, 4);
        chk(0, "T1_load", load_data[0], 32'h44332211);
        chk(0, "T1_nowr", wr_cnt[0] - wc, 0);

        issue(0, LB, 32'h0, 32'h0, 1'b0, 1'b1, a);
        chk(0, "T2_lb", load_data[0], 32'h44000000);
        issue(0, LH, 32'h0, 32'h0, 1'b0, 1'b1, a);
        chk(0, "T2_lh", load_data[0], 32'h44330000);

        wc = wr_cnt[0];
        issue(0, SB, 32'h4, 32'h000000AA, 1'b0, 1'b1, a);
        chk(0, "T3_lat", last_done[0] - a, 5);
        chk(0, "T3_word", mem[0][1], 32'hAA332211);
        chk(0, "T3_onewr", wr_cnt[0] - wc, 1);

        issue(0, SW, 32'h8, 32'hDEADBEEF, 1'b0, 1'b1, a);
        chk(0, "T4_lat", last_done[0] - a, 3);
        chk(0, "T4_word", mem[0][2], 32'hEFBEADDE);

        issue(0, SH, 32'hC, 32'h0000BBCC, 1'b0, 1'b1, a);
        chk(0, "sh_lat", last_done[0] - a, 5);
        chk(0, "sh_word", mem[0][3], 32'hCCBBB0A0);

        issue(1, LW, 32'h8, 32'h0, 1'b1, 1'b1, a);
        chk(1, "lw3_lat", last_done[1] - a, 6);
        chk(1, "lw3_load", load_data[1], 32'h88776655);
        issue(1, LH, 32'h8, 32'h0, 1'b0, 1'b1, a);
        chk(1, "T5_lh_lat", last_done[1] - a, 6);
        chk(1, "T5_lh_load", load_data[1], 32'h88770000);

        wc = wr_cnt[0];
        ld0 = load_data[0];
        issue(0, BAD, 32'h10, 32'h0, 1'b1, 1'b1, a);
        chk(0, "T6_ill_lat", last_done[0] - a, 1);
        chk(0, "T6_ill_mis", last_mis[0], 0);
        chk(0, "T6_ill_load", load_data[0], 32'h44330000);
        issue(0, LW, 32'h2, 32'h0, 1'b1, 1'b1, a);
        chk(0, "T6_lw2_lat", last_done[0] - a, ALIGN ? 1 : 4);
        chk(0, "T6_lw2_mis", last_mis[0], ALIGN);
        chk(0, "T6_lw2_load", load_data[0], ALIGN ? 32'h44330000 : 32'h44332211);
        chk(0, "T6_nowr", wr_cnt[0] - wc, 0);
        ld0 = last_done[1];

        issue(1, LH, 32'h8, 32'h0, 1'b0, 1'b0, a);
        tick();
        do_reset(2);
        repeat (8) tick();
        chk(1, "T5_rst_nodone", last_done[1], ld0);
        chk(1, "T5_rst_busy", busy[1], 0);
        issue(1, LW, 32'h0, 32'h0, 1'b1, 1'b1, a);
        chk(1, "T5_after_lat", last_done[1] - a, 6);
        chk(1, "T5_after_load", load_data[1], 32'h44332211);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
